capture_window: RTL

Parametrised next-generation camera pixel capture engine in the camera pixel-clock domain, between the OV7670 parallel bus and the output buffer FIFO. It assembles RAW8 or RGB565/YUV422 pixels and crops them to a programmable window. It decimates by 1, 2 or 4 and tags each pixel with start-of-frame, end-of-line and end-of-frame. It drives a valid/ready stream and detects overflow: on overflow it aborts the frame cleanly instead of corrupting it.

---
 rtl/cap_pkg.sv | 23 ++
 rtl/skid_buf.sv | 46 ++++
 rtl/capture_window.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/cap_pkg.sv
// Shared types and helpers for the camera capture window engine.
package cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    DROP
  } state_t;

  localparam logic MODE_2B   = 1'b0;
  localparam logic MODE_RAW8 = 1'b1;

  // Decimation step D from the 2-bit select; 3 folds onto /4.
  function automatic logic [2:0] decim_d(input logic [1:0] dec);
    case (dec)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer with registered output; 1 cycle in-to-out.
// Accepts a push while full only if a pop happens in the same cycle.
module skid_buf #(
  parameter int W = 19
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_vld,
  input  logic [W-1:0] i_dat,
  output logic         o_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  input  logic         i_rdy
);

  logic [W-1:0] r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign o_vld  = (r_cnt != 2'd0);
  assign o_dat  = r_mem[r_rd_ptr];
  assign w_pop  = o_vld & i_rdy;
  assign o_rdy  = (r_cnt != 2'd2) | i_rdy;
  assign w_push = i_vld & o_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/capture_window.sv
// Camera pixel capture: assemble, crop, decimate and tag pixels; 2-cycle latency.
// Backpressure via a 2-entry skid buffer; a kept pixel hitting a full buffer aborts the frame.
module capture_window
  import cap_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PIX_W  = 16,
  parameter int XW     = 11,
  parameter int YW     = 10
) (
  input  logic              i_pclk,
  input  logic              i_rst,
  input  logic              i_cfg_done,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_mode,
  input  logic [1:0]        i_decim,
  input  logic [XW-1:0]     i_x0,
  input  logic [YW-1:0]     i_y0,
  input  logic [XW-1:0]     i_w,
  input  logic [YW-1:0]     i_h,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PIX_W-1:0]  o_pix,
  output logic              o_sof,
  output logic              o_eol,
  output logic              o_eof,
  output logic              o_frame_err,
  output logic [15:0]       o_drop_cnt,
  output logic [15:0]       o_frame_cnt
);

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             sof;
    logic             eol;
    logic             eof;
  } beat_t;

  state_t r_state, w_next_state;
  logic              r_vs, r_vs_d, r_hr, r_hr_d;
  logic [DATA_W-1:0] r_d, r_hi;
  logic              r_phase;
  logic [XW-1:0]     r_x, r_x0, r_w;
  logic [YW-1:0]     r_y, r_y0, r_h;
  logic              r_mode;
  logic [2:0]        r_dd;
  logic              r_frame_err;
  logic [15:0]       r_drop_cnt, r_frame_cnt;

  logic w_vs_fall, w_vs_rise, w_hr_rise, w_hr_fall;
  logic w_phase, w_pix_done, w_keep, w_push, w_abort;
  logic w_skid_rdy, w_out_vld;
  logic [XW-1:0] w_x;
  logic [XW:0]   w_xe, w_x0e, w_xend, w_dx, w_xmask;
  logic [YW:0]   w_ye, w_y0e, w_yend, w_dy, w_ymask;
  logic w_in_x, w_in_y, w_dec_ok, w_last_x, w_last_y;
  beat_t w_beat, w_out;

  assign w_vs_fall = r_vs_d & ~r_vs;
  assign w_vs_rise = ~r_vs_d & r_vs;
  assign w_hr_rise = ~r_hr_d & r_hr;
  assign w_hr_fall = r_hr_d & ~r_hr;

  // The first byte of a row is seen on the href-rise cycle, before r_phase/r_x clear.
  assign w_phase    = w_hr_rise ? 1'b0 : r_phase;
  assign w_pix_done = r_hr & ((r_mode == MODE_RAW8) | w_phase);
  assign w_x        = w_hr_rise ? '0 : r_x;

  // Window tests at one extra bit so x0+w at the top of the range cannot wrap.
  assign w_xe     = {1'b0, w_x};
  assign w_x0e    = {1'b0, r_x0};
  assign w_xend   = w_x0e + {1'b0, r_w};
  assign w_dx     = w_xe - w_x0e;
  assign w_xmask  = (XW+1)'(r_dd - 3'd1);
  assign w_ye     = {1'b0, r_y};
  assign w_y0e    = {1'b0, r_y0};
  assign w_yend   = w_y0e + {1'b0, r_h};
  assign w_dy     = w_ye - w_y0e;
  assign w_ymask  = (YW+1)'(r_dd - 3'd1);
  assign w_in_x   = (w_xe >= w_x0e) && (w_xe < w_xend);
  assign w_in_y   = (w_ye >= w_y0e) && (w_ye < w_yend);
  assign w_dec_ok = ((w_dx & w_xmask) == '0) && ((w_dy & w_ymask) == '0);
  assign w_last_x = (w_dx + (XW+1)'(r_dd)) >= {1'b0, r_w};
  assign w_last_y = (w_dy + (YW+1)'(r_dd)) >= {1'b0, r_h};
  assign w_keep   = w_pix_done & w_in_x & w_in_y & w_dec_ok;

  assign w_beat.pix = (r_mode == MODE_RAW8) ? PIX_W'(r_d) : PIX_W'({r_hi, r_d});
  assign w_beat.sof = (w_dx == '0) && (w_dy == '0);
  assign w_beat.eol = w_last_x;
  assign w_beat.eof = w_last_x & w_last_y;

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE:     if (i_cfg_done) w_next_state = WAIT_SOF;
      WAIT_SOF: if (w_vs_fall) w_next_state = ACTIVE;
      ACTIVE: begin
        if (w_vs_rise) begin
          w_abort      = 1'b1;
          w_next_state = WAIT_SOF;
        end else if (w_keep) begin
          if (!w_skid_rdy) begin
            w_abort      = 1'b1;
            w_next_state = DROP;
          end else begin
            w_push = 1'b1;
            if (w_beat.eof) w_next_state = WAIT_SOF;
          end
        end
      end
      DROP:     if (w_vs_rise) w_next_state = WAIT_SOF;
      default:  w_next_state = IDLE;
    endcase
    if (!i_cfg_done) begin
      w_next_state = IDLE;
      w_push       = 1'b0;
      w_abort      = 1'b0;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_vs <= 1'b0;  r_vs_d <= 1'b0;  r_hr <= 1'b0;  r_hr_d <= 1'b0;
      r_d <= '0;  r_hi <= '0;  r_phase <= 1'b0;  r_x <= '0;  r_y <= '0;
      r_mode <= MODE_2B;  r_dd <= 3'd1;
      r_x0 <= '0;  r_y0 <= '0;  r_w <= '0;  r_h <= '0;
      r_frame_err <= 1'b0;  r_drop_cnt <= '0;  r_frame_cnt <= '0;
    end else begin
      r_vs   <= i_vsync;
      r_vs_d <= r_vs;
      r_hr   <= i_href;
      r_hr_d <= r_hr;
      r_d    <= i_data;
      if (r_hr) begin
        r_phase <= ~w_phase;
        r_x     <= w_pix_done ? w_x + XW'(1) : w_x;
        if (!w_phase) r_hi <= r_d;
      end
      if (w_vs_fall)      r_y <= '0;
      else if (w_hr_fall) r_y <= r_y + YW'(1);
      if (r_state == WAIT_SOF && w_next_state == ACTIVE) begin
        r_mode <= i_mode;  r_dd <= decim_d(i_decim);
        r_x0 <= i_x0;  r_y0 <= i_y0;  r_w <= i_w;  r_h <= i_h;
      end
      r_frame_err <= w_abort;
      if (w_abort && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_out_vld && i_ready && w_out.eof) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  skid_buf #(.W($bits(beat_t))) u_skid (
    .i_clk (i_pclk),
    .i_rst (i_rst),
    .i_vld (w_push),
    .i_dat (w_beat),
    .o_rdy (w_skid_rdy),
    .o_vld (w_out_vld),
    .o_dat (w_out),
    .i_rdy (i_ready)
  );

  assign o_valid     = w_out_vld;
  assign o_pix       = w_out.pix;
  assign o_sof       = w_out.sof;
  assign o_eol       = w_out.eol;
  assign o_eof       = w_out.eof;
  assign o_frame_err = r_frame_err;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_frame_cnt = r_frame_cnt;

endmodule
